// File: rtl/router_event_stats_pkg.sv
// Shared types and constants for the router event statistics block.
//   router_event_t : per-port event record emitted by the router top each cycle
//   stats_sel_t    : read-port counter selector (STATS_SEL_* encodings)
package router_event_stats_pkg;

  // Width of the bypassed hop count carried in router_event_t.
  localparam int unsigned BYPASSw = 4;

  // Number of counters kept per port.
  localparam int unsigned NUM_SEL = 6;

  typedef logic [2:0] stats_sel_t;

  localparam stats_sel_t STATS_SEL_FLIT_IN   = 3'd0;
  localparam stats_sel_t STATS_SEL_PCK_IN    = 3'd1;
  localparam stats_sel_t STATS_SEL_FLIT_OUT  = 3'd2;
  localparam stats_sel_t STATS_SEL_PCK_OUT   = 3'd3;
  localparam stats_sel_t STATS_SEL_BYPASS    = 3'd4;
  localparam stats_sel_t STATS_SEL_HOPS_SKIP = 3'd5;

  typedef struct packed {
    logic               flit_wr_i;
    logic               pck_wr_i;
    logic               flit_wr_o;
    logic               pck_wr_o;
    logic               flit_in_bypassed;
    logic [BYPASSw-1:0] bypassed_num;
    logic               empty;
    logic               active_high_reset;
  } router_event_t;

endpackage

// File: rtl/router_event_ctr.sv
// Saturating accumulator.
//   clk, reset : clock, asynchronous active-low reset
//   en         : add inc this cycle
//   clr        : synchronous clear, wins over en
//   inc        : amount to add
//   cnt_o      : current count
//   sat_o      : this cycle's add would exceed all-ones (count clamps instead)
module router_event_ctr #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] inc,
  output logic [W-1:0] cnt_o,
  output logic         sat_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + {1'b0, inc};
    cnt_d = cnt_q;
    sat_o = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (sum[W]) begin
        cnt_d = '1;
        sat_o = 1'b1;
      end else begin
        cnt_d = sum[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/router_event_stats.sv
// Per-router traffic statistics: six saturating counters per port, sticky
// per-port overflow flags, quiescence detection and a 1-cycle-latency read port.
//   clk, reset        : clock, asynchronous active-low reset
//   router_event      : per-port event records from the router
//   en_i, clr_i       : counter enable, synchronous clear
//   rd_req_i/port/sel : read request, port and counter selector
//   rd_valid_o/data/err : read response (error on bad port or selector)
//   ovf_o             : sticky per-port saturation flags
//   idle_o            : router quiescent for at least IDLE_TH cycles
module router_event_stats
  import router_event_stats_pkg::*;
#(
  parameter int          NOC_ID  = 0,
  parameter int unsigned P       = 5,
  parameter int unsigned CNTw    = 32,
  parameter int unsigned IDLEw   = 16,
  parameter int unsigned IDLE_TH = 64,
  localparam int unsigned PW     = (P > 1) ? $clog2(P) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  router_event_t [P-1:0]   router_event,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic                    rd_req_i,
  input  logic [PW-1:0]           rd_port_i,
  input  stats_sel_t              rd_sel_i,
  output logic                    rd_valid_o,
  output logic [CNTw-1:0]         rd_data_o,
  output logic                    rd_err_o,
  output logic [P-1:0]            ovf_o,
  output logic                    idle_o
);

  localparam logic [IDLEw-1:0] IdleThM1 = IDLEw'(IDLE_TH - 1);

  logic [CNTw-1:0]    cnt [P][NUM_SEL];
  logic [NUM_SEL-1:0] sat [P];
  logic [P-1:0]       ahr;

  for (genvar p = 0; p < P; p++) begin : g_port
    logic [CNTw-1:0] inc [NUM_SEL];

    assign inc[STATS_SEL_FLIT_IN]   = CNTw'(router_event[p].flit_wr_i);
    assign inc[STATS_SEL_PCK_IN]    = CNTw'(router_event[p].pck_wr_i);
    assign inc[STATS_SEL_FLIT_OUT]  = CNTw'(router_event[p].flit_wr_o);
    assign inc[STATS_SEL_PCK_OUT]   = CNTw'(router_event[p].pck_wr_o);
    assign inc[STATS_SEL_BYPASS]    = CNTw'(router_event[p].flit_in_bypassed);
    assign inc[STATS_SEL_HOPS_SKIP] = router_event[p].flit_wr_i ?
                                      CNTw'(router_event[p].bypassed_num) : '0;

    for (genvar s = 0; s < NUM_SEL; s++) begin : g_sel
      router_event_ctr #(
        .W(CNTw)
      ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .en    (en_i),
        .clr   (clr_i),
        .inc   (inc[s]),
        .cnt_o (cnt[p][s]),
        .sat_o (sat[p][s])
      );
    end

    assign ahr[p] = router_event[p].active_high_reset;
  end

  // Idle tracking: any non-empty port or a clear restarts the count.
  logic             all_empty;
  logic [IDLEw-1:0] idle_cnt;
  logic             idle_sat;
  logic             idle_d, idle_q;

  always_comb begin
    all_empty = 1'b1;
    for (int unsigned p = 0; p < P; p++) begin
      all_empty = all_empty & router_event[p].empty;
    end
  end

  router_event_ctr #(
    .W(IDLEw)
  ) u_idle_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (clr_i | ~all_empty),
    .inc   (IDLEw'(1)),
    .cnt_o (idle_cnt),
    .sat_o (idle_sat)
  );

  // Registered compare against the next idle count, so idle_o drops the
  // cycle right after activity. Saturation stays >= IDLE_TH.
  assign idle_d = all_empty & ~clr_i & (idle_cnt >= IdleThM1);

  // Sticky overflow.
  logic [P-1:0] ovf_d, ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    for (int unsigned p = 0; p < P; p++) begin
      if (|sat[p]) ovf_d[p] = 1'b1;
    end
    if (clr_i) ovf_d = '0;
  end

  // Read mux: no match (bad port or selector) leaves zero.
  logic            rd_bad;
  logic [CNTw-1:0] rd_mux;

  always_comb begin
    rd_bad = (32'(rd_port_i) >= P) || (rd_sel_i > STATS_SEL_HOPS_SKIP);
    rd_mux = '0;
    for (int unsigned p = 0; p < P; p++) begin
      for (int unsigned s = 0; s < NUM_SEL; s++) begin
        if (rd_port_i == PW'(p) && rd_sel_i == 3'(s)) rd_mux = cnt[p][s];
      end
    end
  end

  logic            rd_valid_q, rd_err_q;
  logic [CNTw-1:0] rd_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= '0;
      idle_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_req_i;
      rd_err_q   <= rd_req_i & rd_bad;
      if (rd_req_i) rd_data_q <= rd_mux;
      ovf_q      <= ovf_d;
      idle_q     <= idle_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;
  assign rd_data_o  = rd_data_q;
  assign ovf_o      = ovf_q;
  assign idle_o     = idle_q;

  logic unused_ok;
  assign unused_ok = ^{ahr, idle_sat} ^ (NOC_ID != 0);

endmodule

// File: tb/tb_router_event_stats.sv
module tb_router_event_stats;
  import router_event_stats_pkg::*;

  localparam int unsigned P       = 5;
  localparam int unsigned CNTw    = 4;
  localparam int unsigned IDLEw   = 16;
  localparam int unsigned IDLE_TH = 64;
  localparam int unsigned PW      = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  router_event_t [P-1:0] ev;
  logic                  en_i, clr_i, rd_req_i;
  logic [PW-1:0]         rd_port_i;
  stats_sel_t            rd_sel_i;
  logic                  rd_valid_o, rd_err_o, idle_o;
  logic [CNTw-1:0]       rd_data_o;
  logic [P-1:0]          ovf_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  router_event_stats #(
    .NOC_ID (0),
    .P      (P),
    .CNTw   (CNTw),
    .IDLEw  (IDLEw),
    .IDLE_TH(IDLE_TH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .router_event(ev),
    .en_i        (en_i),
    .clr_i       (clr_i),
    .rd_req_i    (rd_req_i),
    .rd_port_i   (rd_port_i),
    .rd_sel_i    (rd_sel_i),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .rd_err_o    (rd_err_o),
    .ovf_o       (ovf_o),
    .idle_o      (idle_o)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev(input logic empty);
    for (int i = 0; i < P; i++) begin
      ev[i] = '0;
      ev[i].empty = empty;
    end
  endtask

  // Issue one read; response is visible on return.
  task automatic read(input logic [PW-1:0] port, input stats_sel_t sel);
    rd_req_i  = 1'b1;
    rd_port_i = port;
    rd_sel_i  = sel;
    cycle();
    rd_req_i  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; en_i = 1'b1; clr_i = 1'b0; rd_req_i = 1'b0;
    rd_port_i = '0; rd_sel_i = '0;
    clear_ev(1'b0);
    cycle(); cycle();
    checks++;
    if (rd_valid_o !== 1'b0 || rd_data_o !== 4'd0 || rd_err_o !== 1'b0 ||
        ovf_o !== 5'b0 || idle_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%0d err=%b ovf=%b idle=%b, expected all 0",
               rd_valid_o, rd_data_o, rd_err_o, ovf_o, idle_o);
    end
    reset = 1'b1;
    cycle();
    read(3'd0, STATS_SEL_FLIT_IN);
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 4'd0 || rd_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_read: valid=%b data=%0d err=%b, expected 1/0/0",
               rd_valid_o, rd_data_o, rd_err_o);
    end
  endtask

  task automatic test_flit_count();
    for (int i = 0; i < 10; i++) begin
      ev[2].flit_wr_i = 1'b1;
      ev[2].pck_wr_i  = (i == 3 || i == 7);
      cycle();
    end
    clear_ev(1'b0);
    read(3'd2, STATS_SEL_FLIT_OUT);
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 4'd0 || rd_err_o !== 1'b0) begin
      errors++;
      $display("FAIL flit_out_p2: valid=%b data=%0d err=%b, expected 1/0/0",
               rd_valid_o, rd_data_o, rd_err_o);
    end
    read(3'd2, STATS_SEL_PCK_IN);
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 4'd2 || rd_err_o !== 1'b0) begin
      errors++;
      $display("FAIL pck_in_p2: valid=%b data=%0d err=%b, expected 1/2/0",
               rd_valid_o, rd_data_o, rd_err_o);
    end
    read(3'd2, STATS_SEL_FLIT_IN);
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 4'd10 || rd_err_o !== 1'b0) begin
      errors++;
      $display("FAIL flit_in_p2: valid=%b data=%0d err=%b, expected 1/10/0",
               rd_valid_o, rd_data_o, rd_err_o);
    end
    cycle();
    checks++;
    if (rd_valid_o !== 1'b0 || rd_data_o !== 4'd10 || rd_err_o !== 1'b0) begin
      errors++;
      $display("FAIL no_req_hold: valid=%b data=%0d err=%b, expected 0/10/0",
               rd_valid_o, rd_data_o, rd_err_o);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 15; i++) begin
      ev[0].flit_wr_o = 1'b1;
      cycle();
    end
    checks++;
    if (ovf_o !== 5'b00000) begin
      errors++;
      $display("FAIL ovf_at_max: ovf=%b, expected 00000", ovf_o);
    end
    for (int i = 0; i < 5; i++) cycle();
    clear_ev(1'b0);
    read(3'd0, STATS_SEL_FLIT_OUT);
    checks++;
    if (rd_data_o !== 4'd15 || ovf_o !== 5'b00001) begin
      errors++;
      $display("FAIL saturate: data=%0d ovf=%b, expected 15/00001", rd_data_o, ovf_o);
    end
    clr_i = 1'b1;
    cycle();
    clr_i = 1'b0;
    read(3'd0, STATS_SEL_FLIT_OUT);
    checks++;
    if (rd_data_o !== 4'd0 || ovf_o !== 5'b00000) begin
      errors++;
      $display("FAIL sat_clear: data=%0d ovf=%b, expected 0/00000", rd_data_o, ovf_o);
    end
  endtask

  task automatic test_clear_priority();
    for (int i = 0; i < 5; i++) begin
      ev[1].flit_wr_i = 1'b1;
      cycle();
    end
    // Clear, increment and read in the same cycle.
    clr_i = 1'b1;
    rd_req_i = 1'b1; rd_port_i = 3'd1; rd_sel_i = STATS_SEL_FLIT_IN;
    cycle();
    clr_i = 1'b0;
    ev[1].flit_wr_i = 1'b0;
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 4'd5) begin
      errors++;
      $display("FAIL clr_old_value: valid=%b data=%0d, expected 1/5", rd_valid_o, rd_data_o);
    end
    cycle();
    rd_req_i = 1'b0;
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 4'd0) begin
      errors++;
      $display("FAIL clr_wins: valid=%b data=%0d, expected 1/0", rd_valid_o, rd_data_o);
    end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 4; i++) begin
      ev[3].flit_wr_i        = 1'b1;
      ev[3].bypassed_num     = 4'd3;
      ev[3].flit_in_bypassed = (i < 2);
      cycle();
    end
    // Held while disabled.
    en_i = 1'b0;
    ev[3].flit_in_bypassed = 1'b1;
    cycle();
    en_i = 1'b1;
    clear_ev(1'b0);
    read(3'd3, STATS_SEL_HOPS_SKIP);
    checks++;
    if (rd_data_o !== 4'd12 || rd_err_o !== 1'b0) begin
      errors++;
      $display("FAIL hops_skip: data=%0d err=%b, expected 12/0", rd_data_o, rd_err_o);
    end
    read(3'd3, STATS_SEL_BYPASS);
    checks++;
    if (rd_data_o !== 4'd2) begin
      errors++;
      $display("FAIL bypass: data=%0d, expected 2", rd_data_o);
    end
    read(3'd3, STATS_SEL_FLIT_IN);
    checks++;
    if (rd_data_o !== 4'd4 || ovf_o !== 5'b00000) begin
      errors++;
      $display("FAIL en_hold: data=%0d ovf=%b, expected 4/00000", rd_data_o, ovf_o);
    end
  endtask

  task automatic test_idle();
    clear_ev(1'b1);
    for (int i = 0; i < 63; i++) cycle();
    checks++;
    if (idle_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_63: idle=%b, expected 0", idle_o);
    end
    cycle(); cycle();
    checks++;
    if (idle_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_65: idle=%b, expected 1", idle_o);
    end
    ev[4].empty = 1'b0;
    cycle();
    ev[4].empty = 1'b1;
    checks++;
    if (idle_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_drop: idle=%b, expected 0", idle_o);
    end
    cycle();
    checks++;
    if (idle_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_restart: idle=%b, expected 0", idle_o);
    end
    clear_ev(1'b0);
  endtask

  task automatic test_bad_read();
    read(3'd7, STATS_SEL_FLIT_IN);
    checks++;
    if (rd_valid_o !== 1'b1 || rd_err_o !== 1'b1 || rd_data_o !== 4'd0) begin
      errors++;
      $display("FAIL bad_port: valid=%b err=%b data=%0d, expected 1/1/0",
               rd_valid_o, rd_err_o, rd_data_o);
    end
    read(3'd3, STATS_SEL_FLIT_IN);
    read(3'd3, 3'd6);
    checks++;
    if (rd_valid_o !== 1'b1 || rd_err_o !== 1'b1 || rd_data_o !== 4'd0) begin
      errors++;
      $display("FAIL bad_sel: valid=%b err=%b data=%0d, expected 1/1/0",
               rd_valid_o, rd_err_o, rd_data_o);
    end
    read(3'd3, STATS_SEL_FLIT_IN);
    checks++;
    if (rd_valid_o !== 1'b1 || rd_err_o !== 1'b0 || rd_data_o !== 4'd4) begin
      errors++;
      $display("FAIL good_after_bad: valid=%b err=%b data=%0d, expected 1/0/4",
               rd_valid_o, rd_err_o, rd_data_o);
    end
    // Reset while a response is on the outputs.
    reset = 1'b0;
    #1;
    checks++;
    if (rd_valid_o !== 1'b0 || rd_data_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_read: valid=%b data=%0d, expected 0/0", rd_valid_o, rd_data_o);
    end
    cycle();
    reset = 1'b1;
    cycle();
    read(3'd3, STATS_SEL_FLIT_IN);
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_clears_cnt: valid=%b data=%0d, expected 1/0", rd_valid_o, rd_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_flit_count();
    test_saturation();
    test_clear_priority();
    test_bypass();
    test_idle();
    test_bad_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
